// File: rtl/siso_shift_sched_nb.sv
// Round-robin two-requester scheduler that is the sole master of an external SISO shifter.
// Optional post-burst zero flush enabled by defining SISO_SHIFT_SCHED_CLEAR_EN.
//
// state  | meaning
// IDLE   | no owner, arbitrate on REQ
// RUN    | stream owner's burst, LEN+SISO_WIDTH shifts
// CLR    | flush SISO_WIDTH zeros (only with SISO_SHIFT_SCHED_CLEAR_EN)
// FIN    | DONE pulse, update round-robin pointer
module siso_shift_sched_nb #(
  parameter int BUS_WIDTH  = 8,
  parameter int SISO_WIDTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           REQ,
  input  logic [LEN_W-1:0]     REQ0_LEN,
  input  logic [LEN_W-1:0]     REQ1_LEN,
  input  logic                 REQ0_DIR,
  input  logic                 REQ1_DIR,
  input  logic [BUS_WIDTH-1:0] IN0_DATA,
  input  logic [BUS_WIDTH-1:0] IN1_DATA,
  input  logic                 IN0_VALID,
  input  logic                 IN1_VALID,
  output logic                 IN0_READY,
  output logic                 IN1_READY,
  output logic [1:0]           GRANT,
  output logic [1:0]           SR_SHIFT,
  output logic [BUS_WIDTH-1:0] SR_IN,
  input  logic [BUS_WIDTH-1:0] SR_OUT,
  output logic [BUS_WIDTH-1:0] OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OUT_ID,
  output logic                 DONE
);

  localparam int KW = LEN_W + 1 + $clog2(SISO_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLR, S_FIN} state_t;

  state_t           r_state;
  logic             r_owner;
  logic             r_last;
  logic             r_dir;
  logic [LEN_W-1:0] r_len;
  logic [KW-1:0]    r_k;
  logic [1:0]       r_grant;
  logic             r_done;

  logic [KW-1:0]        w_len_ext;
  logic [KW-1:0]        w_total;
  logic                 w_run;
  logic                 w_clr;
  logic                 w_need_in;
  logic                 w_need_out;
  logic                 w_in_valid;
  logic [BUS_WIDTH-1:0] w_in_data;
  logic                 w_fire;
  logic [1:0]           w_dir_code;
  logic                 w_win;

  assign w_len_ext  = KW'(r_len);
  assign w_total    = w_len_ext + KW'(SISO_WIDTH);
  assign w_run      = (r_state == S_RUN);
`ifdef SISO_SHIFT_SCHED_CLEAR_EN
  assign w_clr      = (r_state == S_CLR);
`else
  assign w_clr      = 1'b0;
`endif
  assign w_need_in  = (r_k < w_len_ext);
  assign w_need_out = (r_k >= KW'(SISO_WIDTH));
  assign w_in_valid = r_owner ? IN1_VALID : IN0_VALID;
  assign w_in_data  = r_owner ? IN1_DATA : IN0_DATA;
  assign w_fire     = w_run & (~w_need_in | w_in_valid) & (~w_need_out | OUT_READY);
  assign w_dir_code = r_dir ? 2'b10 : 2'b01;
  // Both requesting: the one not served last wins; reset leaves requester 0 favoured.
  assign w_win      = (REQ == 2'b11) ? ~r_last : REQ[1];

  assign SR_SHIFT  = (w_fire | w_clr) ? w_dir_code : 2'b00;
  assign SR_IN     = (w_fire & w_need_in) ? w_in_data : '0;
  assign IN0_READY = w_fire & w_need_in & ~r_owner;
  assign IN1_READY = w_fire & w_need_in & r_owner;
  assign OUT_VALID = w_run & w_need_out & (~w_need_in | w_in_valid);
  assign OUT_DATA  = OUT_VALID ? SR_OUT : '0;
  assign OUT_ID    = r_owner;
  assign GRANT     = r_grant;
  assign DONE      = r_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_dir   <= 1'b0;
      r_len   <= '0;
      r_k     <= '0;
      r_grant <= 2'b00;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (REQ != 2'b00) begin
            r_owner <= w_win;
            r_len   <= w_win ? REQ1_LEN : REQ0_LEN;
            r_dir   <= w_win ? REQ1_DIR : REQ0_DIR;
            r_k     <= '0;
            r_grant <= w_win ? 2'b10 : 2'b01;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (r_k == w_total - KW'(1)) begin
`ifdef SISO_SHIFT_SCHED_CLEAR_EN
              r_k     <= '0;
              r_state <= S_CLR;
`else
              r_grant <= 2'b00;
              r_done  <= 1'b1;
              r_state <= S_FIN;
`endif
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        S_CLR: begin
          // Flush runs unconditionally; no consumer handshake is involved.
          if (r_k == KW'(SISO_WIDTH - 1)) begin
            r_grant <= 2'b00;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_FIN: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
